// File: rtl/spi_slave_regs_if.sv
// rtl/spi_slave_regs_if.sv - SPI pins and host register port of spi_slave_regs
interface spi_slave_regs_if #(
  parameter int ADDR_LEN = 4
);
  logic                SPI_SCLK;
  logic                CS;
  logic                MOSI;
  logic                MISO;
  logic [ADDR_LEN-1:0] host_addr;
  logic                host_we;
  logic [7:0]          host_wdata;
  logic [7:0]          host_rdata;

  modport master (
    output SPI_SCLK, CS, MOSI, host_addr, host_we, host_wdata,
    input  MISO, host_rdata
  );

  modport slave (
    input  SPI_SCLK, CS, MOSI, host_addr, host_we, host_wdata,
    output MISO, host_rdata
  );
endinterface

// File: rtl/spi_slave_regs.sv
// rtl/spi_slave_regs.sv - oversampled SPI responder over a byte-wide register file
module spi_slave_regs #(
  parameter int         REG_COUNT   = 16,
  parameter int         ADDR_LEN    = 4,
  parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  spi_slave_regs_if.slave     bus,
  input  logic                CPOL,
  input  logic                default_val,
  output logic                busy,
  output logic                spi_wr_strobe,
  output logic                spi_rd_strobe,
  output logic [ADDR_LEN-1:0] spi_addr
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_CS} state_t;

  state_t     state;
  logic [1:0] sclk_sync, cs_sync, mosi_sync;
  logic       s_q, cs_q;
  logic [4:0] bit_cnt;
  logic [7:0] rx_sr, tx_sr, commit_data;
  logic       is_read, in_range;
  logic [7:0] regs [REG_COUNT];

  logic       s, lead, trail, cs_fall, cs_high;
  logic [7:0] rx_next, rd_lookup;
  logic       cmd_in_range, host_in_range;

  always_comb begin
    s             = sclk_sync[1] ^ CPOL;
    lead          = s & ~s_q;
    trail         = ~s & s_q;
    cs_fall       = cs_q & ~cs_sync[1];
    cs_high       = cs_sync[1];
    rx_next       = {rx_sr[6:0], mosi_sync[1]};
    cmd_in_range  = ({25'd0, rx_next[6:0]} < REG_COUNT);
    host_in_range = ({{(32-ADDR_LEN){1'b0}}, bus.host_addr} < REG_COUNT);
    rd_lookup     = cmd_in_range ? regs[rx_next[ADDR_LEN-1:0]] : 8'h00;
  end

  // CS flops reset low so a frame already open at reset release never shows a falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      s_q       <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], bus.SPI_SCLK};
      cs_sync   <= {cs_sync[0], bus.CS};
      mosi_sync <= {mosi_sync[0], bus.MOSI};
      s_q       <= s;
      cs_q      <= cs_sync[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.MISO      <= default_val;
      busy          <= 1'b0;
      spi_wr_strobe <= 1'b0;
      spi_rd_strobe <= 1'b0;
      spi_addr      <= '0;
      bit_cnt       <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      commit_data   <= '0;
      is_read       <= 1'b0;
      in_range      <= 1'b0;
    end else begin
      spi_wr_strobe <= 1'b0;
      spi_rd_strobe <= 1'b0;
      case (state)
        IDLE: begin
          bus.MISO <= default_val;
          busy     <= 1'b0;
          bit_cnt  <= '0;
          if (cs_fall) begin
            state    <= CMD;
            busy     <= 1'b1;
            bus.MISO <= STATUS_BYTE[7];
            tx_sr    <= {STATUS_BYTE[6:0], 1'b0};
          end
        end
        CMD: begin
          if (lead) begin
            rx_sr   <= rx_next;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              is_read       <= rx_next[7];
              in_range      <= cmd_in_range;
              spi_addr      <= rx_next[ADDR_LEN-1:0];
              spi_rd_strobe <= rx_next[7];
              tx_sr         <= rd_lookup;
            end
          end else if (trail) begin
            bus.MISO <= tx_sr[7];
            tx_sr    <= {tx_sr[6:0], 1'b0};
            if (bit_cnt == 5'd8) begin
              state <= DATA;
              if (!is_read) bus.MISO <= default_val;
            end
          end
        end
        DATA: begin
          if (lead) begin
            rx_sr   <= rx_next;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              state         <= WAIT_CS;
              bus.MISO      <= default_val;
              commit_data   <= rx_next;
              spi_wr_strobe <= !is_read && in_range;
            end
          end else if (trail) begin
            bus.MISO <= is_read ? tx_sr[7] : default_val;
            tx_sr    <= {tx_sr[6:0], 1'b0};
          end
        end
        WAIT_CS: bus.MISO <= default_val;
        default: state <= IDLE;
      endcase
      if (state != IDLE && cs_high) begin
        state         <= IDLE;
        busy          <= 1'b0;
        bus.MISO      <= default_val;
        spi_wr_strobe <= 1'b0;
      end
    end
  end

  // SPI commit is written last so it wins a same-address collision with the host
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'h00;
      bus.host_rdata <= 8'h00;
    end else begin
      if (bus.host_we && host_in_range) regs[bus.host_addr] <= bus.host_wdata;
      if (spi_wr_strobe) regs[spi_addr] <= commit_data;
      bus.host_rdata <= host_in_range ? regs[bus.host_addr] : 8'h00;
    end
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
// tb/tb_spi_slave_regs.sv - directed scoreboard bench for spi_slave_regs
module tb_spi_slave_regs;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpol = 1'b0;
  logic       dflt = 1'b0;
  logic       busy, wr_s, rd_s;
  logic [3:0] spi_addr;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [23:0] rx_q [$];
  int          wr_q [$];
  int          rd_q [$];

  spi_slave_regs_if #(.ADDR_LEN(4)) bus ();

  spi_slave_regs #(.REG_COUNT(12), .ADDR_LEN(4), .STATUS_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .CPOL(cpol), .default_val(dflt),
    .busy(busy), .spi_wr_strobe(wr_s), .spi_rd_strobe(rd_s), .spi_addr(spi_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Strobes are popped against the addresses queued when the frames were driven
  always @(negedge clk) begin
    if (wr_s) begin
      check("wr_strobe_expected", 32'(wr_q.size() > 0), 1);
      if (wr_q.size() > 0) check("wr_addr", 32'(spi_addr), wr_q.pop_front());
    end
    if (rd_s) begin
      check("rd_strobe_expected", 32'(rd_q.size() > 0), 1);
      if (rd_q.size() > 0) check("rd_addr", 32'(spi_addr), rd_q.pop_front());
    end
  end

  task automatic spi_bits(input int nbits, input logic [23:0] tx, output logic [23:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.MOSI = tx[i];
      wait_clks(HALF);
      rx = {rx[22:0], bus.MISO};
      bus.SPI_SCLK = ~cpol;
      wait_clks(HALF);
      bus.SPI_SCLK = cpol;
    end
  endtask

  task automatic frame(input int nbits, input logic [23:0] tx, input logic [23:0] exp,
                       input string tag);
    logic [23:0] rx;
    rx_q.push_back(exp);
    bus.CS = 1'b0;
    spi_bits(nbits, tx, rx);
    wait_clks(HALF);
    bus.CS = 1'b1;
    wait_clks(2 * HALF);
    check(tag, 32'(rx), 32'(rx_q.pop_front()));
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    bus.host_addr  = a;
    bus.host_wdata = d;
    bus.host_we    = 1'b1;
    @(negedge clk);
    bus.host_we    = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
    bus.host_addr = a;
    wait_clks(2);
    check(tag, 32'(bus.host_rdata), 32'(exp));
  endtask

  task automatic collide(input logic [3:0] sa, input logic [7:0] sd,
                         input logic [3:0] ha, input logic [7:0] hd);
    wr_q.push_back(int'(sa));
    fork
      frame(16, {8'h00, 4'h0, sa, sd}, 24'h00A500, "t5_miso");
      begin
        int k = 0;
        while (!wr_s && k < 2000) begin
          @(negedge clk);
          k++;
        end
        check("t5_strobe_seen", 32'(wr_s), 1);
        host_write(ha, hd);
      end
    join
  endtask

  initial begin
    logic [23:0] rx;
    bus.SPI_SCLK = 1'b0; bus.CS = 1'b1; bus.MOSI = 1'b0;
    bus.host_addr = '0; bus.host_we = 1'b0; bus.host_wdata = '0;
    wait_clks(4);
    check("rst_busy", 32'(busy), 0);
    check("rst_miso", 32'(bus.MISO), 0);
    check("rst_rdata", 32'(bus.host_rdata), 0);
    check("rst_spi_addr", 32'(spi_addr), 0);
    check("rst_strobes", 32'({wr_s, rd_s}), 0);
    rst = 1'b0;
    wait_clks(8);

    // 1: write, CPOL 0
    wr_q.push_back(3);
    frame(16, 24'h00035C, 24'h00A500, "t1_miso");
    host_read(4'd3, 8'h5C, "t1_reg3");

    // 2: read, CPOL 1
    host_write(4'd7, 8'hC3);
    cpol = 1'b1; bus.SPI_SCLK = 1'b1;
    wait_clks(8);
    rd_q.push_back(7);
    frame(16, 24'h008700, 24'h00A5C3, "t2_miso");
    cpol = 1'b0; bus.SPI_SCLK = 1'b0;
    wait_clks(8);

    // 3: abort after 12 bits
    frame(12, 24'h00002F, 24'h000A50, "t3_miso");
    check("t3_busy", 32'(busy), 0);
    host_read(4'd2, 8'h00, "t3_reg2");

    // 4: out of range (REG_COUNT 12)
    frame(16, 24'h000D11, 24'h00A500, "t4_wr_oor_miso");
    rd_q.push_back(13);
    frame(16, 24'h008D00, 24'h00A500, "t4_rd_oor_miso");
    frame(16, 24'h004277, 24'h00A500, "t4_hibit_miso");
    host_read(4'd2, 8'h00, "t4_reg2");
    host_write(4'd13, 8'h55);
    host_read(4'd13, 8'h00, "t4_host_oor");
    wr_q.push_back(11);
    frame(16, 24'h000B66, 24'h00A500, "t4_last_miso");
    host_read(4'd11, 8'h66, "t4_reg11");

    // 5: collisions
    collide(4'd4, 8'h99, 4'd4, 8'h11);
    host_read(4'd4, 8'h99, "t5_same_addr");
    collide(4'd6, 8'h5A, 4'd5, 8'h22);
    host_read(4'd6, 8'h5A, "t5_diff_spi");
    host_read(4'd5, 8'h22, "t5_diff_host");

    // 6: reset mid-frame, then 24-bit overrun frame
    dflt = 1'b1;
    wait_clks(8);
    bus.CS = 1'b0;
    spi_bits(4, 24'h0, rx);
    check("t6_busy_mid", 32'(busy), 1);
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    spi_bits(16, 24'h0001AA, rx);
    check("t6_ignored_miso", 32'(rx), 32'h00FFFF);
    check("t6_ignored_busy", 32'(busy), 0);
    wait_clks(HALF);
    bus.CS = 1'b1;
    wait_clks(2 * HALF);
    host_read(4'd1, 8'h00, "t6_reg1");
    wr_q.push_back(5);
    frame(24, 24'h053CF0, 24'hA5FFFF, "t6_overrun_miso");
    host_read(4'd5, 8'h3C, "t6_reg5");

    check("wr_q_drained", 32'(wr_q.size()), 0);
    check("rd_q_drained", 32'(rd_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
